// File: rtl/piso_transmitter.sv
// Parallel-in serial-out transmitter: latches a WIDTH-bit word on load and
// sends it one bit per clock with a valid strobe. Optional macro: PISO_TRANSMITTER_PARITY_EN.
module piso_transmitter #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int             CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

`ifdef PISO_TRANSMITTER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t           r_state, w_nextState;
   logic [WIDTH-1:0] r_shiftReg, w_nextShift;
   logic [CW-1:0]    r_bitCount, w_nextCount;
   logic             r_out, w_nextOut;
   logic             r_outValid, w_nextValid;
   logic             r_busy, w_nextBusy;
   logic             r_done, w_nextDone;
   logic             r_ready;
`ifdef PISO_TRANSMITTER_PARITY_EN
   logic             r_parity, w_nextParity;
`endif

   // The bit on the line is always the head of the shift register; every
   // output is computed one cycle ahead so it can leave a flop directly.
   always_comb begin
      w_nextState = r_state;
      w_nextShift = r_shiftReg;
      w_nextCount = r_bitCount;
      w_nextOut   = 1'b0;
      w_nextValid = 1'b0;
      w_nextBusy  = 1'b0;
      w_nextDone  = 1'b0;
`ifdef PISO_TRANSMITTER_PARITY_EN
      w_nextParity = r_parity;
`endif
      case (r_state)
         IDLE: begin
            if (load) begin
               w_nextState = SHIFT;
               w_nextShift = data_in;
               w_nextCount = '0;
               w_nextOut   = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
               w_nextValid = 1'b1;
               w_nextBusy  = 1'b1;
`ifdef PISO_TRANSMITTER_PARITY_EN
               w_nextParity = ^data_in;
`endif
            end
         end
         SHIFT: begin
            if (r_bitCount == LAST_BIT) begin
`ifdef PISO_TRANSMITTER_PARITY_EN
               w_nextState = PARITY;
               w_nextOut   = r_parity;
               w_nextValid = 1'b1;
               w_nextBusy  = 1'b1;
`else
               w_nextState = IDLE;
               w_nextDone  = 1'b1;
`endif
            end else begin
               w_nextShift = (MSB_FIRST != 0) ? (r_shiftReg << 1) : (r_shiftReg >> 1);
               w_nextCount = r_bitCount + CW'(1);
               w_nextOut   = (MSB_FIRST != 0) ? w_nextShift[WIDTH-1] : w_nextShift[0];
               w_nextValid = 1'b1;
               w_nextBusy  = 1'b1;
            end
         end
`ifdef PISO_TRANSMITTER_PARITY_EN
         PARITY: begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
         end
`endif
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shiftReg <= '0;
         r_bitCount <= '0;
         r_out      <= 1'b0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_state    <= w_nextState;
         r_shiftReg <= w_nextShift;
         r_bitCount <= w_nextCount;
         r_out      <= w_nextOut;
         r_outValid <= w_nextValid;
         r_busy     <= w_nextBusy;
         r_done     <= w_nextDone;
         r_ready    <= (w_nextState == IDLE);
      end
   end

`ifdef PISO_TRANSMITTER_PARITY_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= w_nextParity;
      end
   end
`endif

   assign ready     = r_ready;
   assign out       = r_out;
   assign out_valid = r_outValid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_piso_transmitter.sv
// Directed bench for piso_transmitter: an LSB-first and an MSB-first instance,
// expected serial bits queued at load time and checked whenever out_valid is high.
module tb_piso_transmitter;

   localparam int W = 4;
`ifdef PISO_TRANSMITTER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int CYC = W + 1 + PAR;

   typedef struct packed {
      logic value;
      logic isParity;
   } expBit_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] dataIn = '0;
   logic [W-1:0] dataInMsb = '0;
   logic         load = 1'b0;
   logic         loadMsb = 1'b0;

   logic readyLsb, outLsb, validLsb, busyLsb, doneLsb;
   logic readyMsb, outMsb, validMsb, busyMsb, doneMsb;

   int           checkCount = 0;
   int           passCount = 0;
   expBit_t      lsbQueue[$];
   expBit_t      msbQueue[$];
   expBit_t      lsbEntry;
   expBit_t      msbEntry;
   logic [W-1:0] rxReg = '0;

   piso_transmitter #(.WIDTH(W), .MSB_FIRST(0)) dut (
      .clock(clock), .reset(reset), .data_in(dataIn), .load(load),
      .ready(readyLsb), .out(outLsb), .out_valid(validLsb), .busy(busyLsb), .done(doneLsb)
   );

   piso_transmitter #(.WIDTH(W), .MSB_FIRST(1)) dutMsb (
      .clock(clock), .reset(reset), .data_in(dataInMsb), .load(loadMsb),
      .ready(readyMsb), .out(outMsb), .out_valid(validMsb), .busy(busyMsb), .done(doneMsb)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Flags are packed as {ready, out_valid, busy, done}.
   task automatic checkFlags(input string tag, input bit msb, input logic [3:0] expected);
      if (msb) checkOutput(tag, {28'd0, readyMsb, validMsb, busyMsb, doneMsb}, {28'd0, expected});
      else     checkOutput(tag, {28'd0, readyLsb, validLsb, busyLsb, doneLsb}, {28'd0, expected});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pushWord(input logic [W-1:0] word, input bit msb);
      expBit_t e;
      for (int i = 0; i < W; i++) begin
         e.value    = msb ? word[W-1-i] : word[i];
         e.isParity = 1'b0;
         if (msb) msbQueue.push_back(e);
         else     lsbQueue.push_back(e);
      end
      if (PAR != 0) begin
         e.value    = ^word;
         e.isParity = 1'b1;
         if (msb) msbQueue.push_back(e);
         else     lsbQueue.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] word, input bit msb);
      if (msb) begin
         loadMsb   = 1'b1;
         dataInMsb = word;
      end else begin
         load   = 1'b1;
         dataIn = word;
      end
      pushWord(word, msb);
   endtask

   task automatic runTransfer(input logic [W-1:0] word, input bit msb);
      rxReg = '0;
      applyStimulus(word, msb);
      tick();
      load    = 1'b0;
      loadMsb = 1'b0;
      for (int k = 0; k < W + PAR; k++) begin
         checkFlags("shiftFlags", msb, 4'b0110);
         tick();
      end
      checkFlags("doneFlags", msb, 4'b1001);
      checkOutput("doneOut", {31'd0, (msb ? outMsb : outLsb)}, 32'd0);
      if (!msb) checkOutput("rxWord", {28'd0, rxReg}, {28'd0, word});
      tick();
      checkFlags("afterDone", msb, 4'b1000);
   endtask

   // Every valid bit must match the next queued expectation in order.
   always @(negedge clock) begin
      if (validLsb) begin
         if (lsbQueue.size() == 0) begin
            checkOutput("lsbUnexpectedValid", 32'd1, 32'd0);
         end else begin
            lsbEntry = lsbQueue.pop_front();
            checkOutput("lsbBit", {31'd0, outLsb}, {31'd0, lsbEntry.value});
            if (!lsbEntry.isParity) rxReg = {outLsb, rxReg[W-1:1]};
         end
      end
      if (validMsb) begin
         if (msbQueue.size() == 0) begin
            checkOutput("msbUnexpectedValid", 32'd1, 32'd0);
         end else begin
            msbEntry = msbQueue.pop_front();
            checkOutput("msbBit", {31'd0, outMsb}, {31'd0, msbEntry.value});
         end
      end
   end

   initial begin
      int doneCount;
      bit doneExp;

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checkFlags("resetLsb", 0, 4'b1000);
      checkFlags("resetMsb", 1, 4'b1000);
      checkOutput("resetOut", {31'd0, outLsb}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkFlags("idleLsb", 0, 4'b1000);
         checkOutput("idleOut", {31'd0, outLsb}, 32'd0);
      end

      runTransfer(4'b1011, 0);
      runTransfer(4'b1000, 1);

      // A load during a transfer is dropped and never queued.
      rxReg = '0;
      applyStimulus(4'b0110, 0);
      tick();
      load = 1'b0;
      tick();
      checkFlags("ignoreBusy", 0, 4'b0110);
      load   = 1'b1;
      dataIn = 4'b1111;
      tick();
      load = 1'b0;
      doneCount = 0;
      for (int c = 3; c <= CYC + 3; c++) begin
         if (doneLsb) doneCount++;
         tick();
      end
      checkOutput("singleDone", doneCount, 1);
      checkOutput("ignoreRx", {28'd0, rxReg}, 32'h6);
      checkFlags("ignoreIdle", 0, 4'b1000);

      // Reset mid-transfer aborts without a done pulse.
      applyStimulus(4'b1011, 0);
      tick();
      load = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      lsbQueue.delete();
      checkFlags("abortFlags", 0, 4'b1000);
      checkOutput("abortOut", {31'd0, outLsb}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkFlags("abortQuiet", 0, 4'b1000);
      end
      runTransfer(4'b0001, 0);

      // Reset wins over a simultaneous load.
      reset  = 1'b1;
      load   = 1'b1;
      dataIn = 4'b1111;
      tick();
      reset = 1'b0;
      load  = 1'b0;
      checkFlags("resetPriority", 0, 4'b1000);
      for (int i = 0; i < W + 1; i++) begin
         tick();
         checkFlags("resetPriorityIdle", 0, 4'b1000);
      end

      // Back-to-back with load held high across the done cycle.
      rxReg = '0;
      applyStimulus(4'b1011, 0);
      tick();
      dataIn = 4'b0011;
      pushWord(4'b0011, 0);
      for (int c = 1; c <= 2 * CYC; c++) begin
         if (c == CYC + 2) load = 1'b0;
         doneExp = (c == CYC) || (c == 2 * CYC);
         checkOutput("b2bDone", {31'd0, doneLsb}, {31'd0, doneExp});
         checkOutput("b2bValid", {31'd0, validLsb}, {31'd0, !doneExp});
         if (c == CYC)     checkOutput("b2bRx1", {28'd0, rxReg}, 32'hB);
         if (c == 2 * CYC) checkOutput("b2bRx2", {28'd0, rxReg}, 32'h3);
         tick();
      end
      checkFlags("b2bIdle", 0, 4'b1000);

      checkOutput("lsbQueueEmpty", lsbQueue.size(), 0);
      checkOutput("msbQueueEmpty", msbQueue.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
